// File: rtl/wbc2pipeline.sv
// wbc2pipeline: classic Wishbone slave to pipelined Wishbone master, one transfer in flight; watchdog under WBC2PIPELINE_TIMEOUT_EN.
// Latency: strobe to ack 3 cycles minimum; i_mstall holds the request steady, the classic side simply waits for o_sack/o_serr.
module wbc2pipeline #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int LGTIMEOUT = 6
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_scyc,
  input  logic            i_sstb,
  input  logic            i_swe,
  input  logic [AW-1:0]   i_saddr,
  input  logic [DW-1:0]   i_sdata,
  input  logic [DW/8-1:0] i_ssel,
  input  logic [2:0]      i_scti,
  input  logic [1:0]      i_sbte,
  output logic            o_sack,
  output logic            o_serr,
  output logic [DW-1:0]   o_sdata,
  output logic            o_mcyc,
  output logic            o_mstb,
  output logic            o_mwe,
  output logic [AW-1:0]   o_maddr,
  output logic [DW-1:0]   o_mdata,
  output logic [DW/8-1:0] o_msel,
  input  logic            i_mstall,
  input  logic            i_mack,
  input  logic            i_merr,
  input  logic [DW-1:0]   i_mdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic            mcyc_nxt, mstb_nxt, mwe_nxt, sack_nxt, serr_nxt;
  logic [AW-1:0]   maddr_nxt;
  logic [DW-1:0]   mdata_nxt, sdata_nxt;
  logic [DW/8-1:0] msel_nxt;
  logic            wdog_expired;
  logic            start;

  // Every beat is a single classic transfer, so the burst hints carry no meaning here.
  logic unused_burst_hints;
  assign unused_burst_hints = ^{i_scti, i_sbte};

  assign start = i_scyc && i_sstb;

`ifdef WBC2PIPELINE_TIMEOUT_EN
  logic [LGTIMEOUT-1:0] wdog;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wdog <= '0;
    end else if (state == S_IDLE) begin
      wdog <= '0;
    end else if (state == S_REQ || state == S_WAIT) begin
      wdog <= wdog + 1'b1;
    end
  end

  assign wdog_expired = &wdog;
`else
  localparam int unused_lgtimeout = LGTIMEOUT;
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_IDLE;
      o_mcyc  <= 1'b0;
      o_mstb  <= 1'b0;
      o_mwe   <= 1'b0;
      o_maddr <= '0;
      o_mdata <= '0;
      o_msel  <= '0;
      o_sack  <= 1'b0;
      o_serr  <= 1'b0;
      o_sdata <= '0;
    end else begin
      state   <= state_nxt;
      o_mcyc  <= mcyc_nxt;
      o_mstb  <= mstb_nxt;
      o_mwe   <= mwe_nxt;
      o_maddr <= maddr_nxt;
      o_mdata <= mdata_nxt;
      o_msel  <= msel_nxt;
      o_sack  <= sack_nxt;
      o_serr  <= serr_nxt;
      o_sdata <= sdata_nxt;
    end
  end

  // Abort beats everything, a real ack beats the watchdog, and the watchdog beats a late acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      S_REQ: begin
        if (!i_scyc)           state_nxt = S_IDLE;
        else if (wdog_expired) state_nxt = S_ACK;
        else if (!i_mstall)    state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!i_scyc)                 state_nxt = S_IDLE;
        else if (i_mack || i_merr)   state_nxt = S_ACK;
        else if (wdog_expired)       state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mcyc_nxt  = o_mcyc;
    mstb_nxt  = o_mstb;
    mwe_nxt   = o_mwe;
    maddr_nxt = o_maddr;
    mdata_nxt = o_mdata;
    msel_nxt  = o_msel;
    sdata_nxt = o_sdata;
    sack_nxt  = 1'b0;
    serr_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          mcyc_nxt  = 1'b1;
          mstb_nxt  = 1'b1;
          mwe_nxt   = i_swe;
          maddr_nxt = i_saddr;
          mdata_nxt = i_sdata;
          msel_nxt  = i_ssel;
        end
      end
      S_REQ: begin
        if (!i_scyc) begin
          mcyc_nxt = 1'b0;
          mstb_nxt = 1'b0;
        end else if (wdog_expired) begin
          mcyc_nxt = 1'b0;
          mstb_nxt = 1'b0;
          serr_nxt = 1'b1;
        end else if (!i_mstall) begin
          mstb_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (!i_scyc) begin
          mcyc_nxt = 1'b0;
          mstb_nxt = 1'b0;
        end else if (i_merr) begin
          mcyc_nxt = 1'b0;
          serr_nxt = 1'b1;
        end else if (i_mack) begin
          mcyc_nxt  = 1'b0;
          sack_nxt  = 1'b1;
          sdata_nxt = i_mdata;
        end else if (wdog_expired) begin
          mcyc_nxt = 1'b0;
          serr_nxt = 1'b1;
        end
      end
      default: begin
        mcyc_nxt = 1'b0;
        mstb_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wbc2pipeline.sv
// Directed bench for wbc2pipeline with an output-level reference model checked every cycle.
module tb_wbc2pipeline;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int LGT = 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_scyc, i_sstb, i_swe;
  logic [AW-1:0] i_saddr;
  logic [DW-1:0] i_sdata;
  logic [SW-1:0] i_ssel;
  logic [2:0]    i_scti;
  logic [1:0]    i_sbte;
  logic          o_sack, o_serr;
  logic [DW-1:0] o_sdata;
  logic          o_mcyc, o_mstb, o_mwe;
  logic [AW-1:0] o_maddr;
  logic [DW-1:0] o_mdata;
  logic [SW-1:0] o_msel;
  logic          i_mstall, i_mack, i_merr;
  logic [DW-1:0] i_mdata;

  wbc2pipeline #(.AW(AW), .DW(DW), .LGTIMEOUT(LGT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe),
    .i_saddr(i_saddr), .i_sdata(i_sdata), .i_ssel(i_ssel),
    .i_scti(i_scti), .i_sbte(i_sbte),
    .o_sack(o_sack), .o_serr(o_serr), .o_sdata(o_sdata),
    .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe),
    .o_maddr(o_maddr), .o_mdata(o_mdata), .o_msel(o_msel),
    .i_mstall(i_mstall), .i_mack(i_mack), .i_merr(i_merr), .i_mdata(i_mdata)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: expected outputs derived from the bus rules, one step per clock.
  logic          e_mcyc, e_mstb, e_mwe, e_sack, e_serr;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_mdata, e_sdata;
  logic [SW-1:0] e_msel;
  int            age;
  bit            m_in_ack;

  function automatic bit m_expired(input int a);
`ifdef WBC2PIPELINE_TIMEOUT_EN
    return a == (1 << LGT) - 1;
`else
    return a < 0;
`endif
  endfunction

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      e_mcyc = 0; e_mstb = 0; e_mwe = 0; e_sack = 0; e_serr = 0;
      e_maddr = '0; e_mdata = '0; e_sdata = '0; e_msel = '0; age = 0;
    end else begin
      m_in_ack = e_sack | e_serr;
      e_sack = 0;
      e_serr = 0;
      if (!e_mcyc) begin
        if (!m_in_ack && i_scyc && i_sstb) begin
          e_mcyc = 1; e_mstb = 1; e_mwe = i_swe;
          e_maddr = i_saddr; e_mdata = i_sdata; e_msel = i_ssel; age = 0;
        end
      end else if (!i_scyc) begin
        e_mcyc = 0; e_mstb = 0;
      end else if (e_mstb) begin
        if (m_expired(age)) begin
          e_mcyc = 0; e_mstb = 0; e_serr = 1;
        end else begin
          if (!i_mstall) e_mstb = 0;
          age++;
        end
      end else if (i_merr) begin
        e_mcyc = 0; e_serr = 1;
      end else if (i_mack) begin
        e_mcyc = 0; e_sack = 1; e_sdata = i_mdata;
      end else if (m_expired(age)) begin
        e_mcyc = 0; e_serr = 1;
      end else begin
        age++;
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("m_sack", o_sack, e_sack);
      check("m_serr", o_serr, e_serr);
      check("m_excl", o_sack & o_serr, 0);
      check("m_mcyc", o_mcyc, e_mcyc);
      check("m_mstb", o_mstb, e_mstb);
      check("m_sdata", o_sdata, e_sdata);
      if (e_mcyc) begin
        check("m_maddr", o_maddr, e_maddr);
        check("m_mdata", o_mdata, e_mdata);
        check("m_msel", o_msel, e_msel);
        check("m_mwe", o_mwe, e_mwe);
      end
    end
  end

  task automatic tick();
    @(negedge i_clk);
    i_scti = 3'($urandom_range(7));
    i_sbte = 2'($urandom_range(3));
  endtask

  task automatic start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    i_scyc = 1; i_sstb = 1; i_swe = we; i_saddr = a; i_sdata = d; i_ssel = s;
  endtask

  task automatic end_cyc();
    i_scyc = 0; i_sstb = 0;
  endtask

  initial begin
    i_reset = 1; i_scyc = 0; i_sstb = 0; i_swe = 0; i_saddr = '0; i_sdata = '0; i_ssel = '0;
    i_scti = '0; i_sbte = '0; i_mstall = 0; i_mack = 0; i_merr = 0; i_mdata = '0;
    tick(); tick();
    check("rst_mcyc", o_mcyc, 0);
    check("rst_sack", o_sack, 0);
    check("rst_sdata", o_sdata, 0);
    check("rst_maddr", o_maddr, 0);
    i_reset = 0;
    chk_en = 1;
    tick();

    // Minimum-latency read
    start(0, 12'h010, 32'h0, 4'hF);
    tick(); check("r_stb1", o_mstb, 1); check("r_addr", o_maddr, 12'h010);
    tick(); check("r_stb2", o_mstb, 0); check("r_cyc", o_mcyc, 1);
    i_mack = 1; i_mdata = 32'hDEADBEEF;
    tick(); i_mack = 0;
    check("r_ack", o_sack, 1); check("r_dat", o_sdata, 32'hDEADBEEF); check("r_cyc_off", o_mcyc, 0);
    end_cyc();
    tick(); check("r_ack_once", o_sack, 0);

    // Write held off by three stall cycles
    start(1, 12'h020, 32'h12345678, 4'hF); i_mstall = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) i_mstall = 0;
      check("w_stb", o_mstb, 1); check("w_dat", o_mdata, 32'h12345678);
      check("w_sel", o_msel, 4'hF); check("w_we", o_mwe, 1);
    end
    tick(); check("w_stb_off", o_mstb, 0); check("w_noack", o_sack, 0);
    i_mack = 1;
    tick(); i_mack = 0; check("w_ack", o_sack, 1); end_cyc();
    tick(); check("w_ack_once", o_sack, 0);

    // Error and ack together: error wins, read data untouched
    start(0, 12'h030, 32'h0, 4'h3);
    tick(); tick();
    i_mack = 1; i_merr = 1; i_mdata = 32'h55555555;
    tick(); i_mack = 0; i_merr = 0;
    check("e_err", o_serr, 1); check("e_noack", o_sack, 0); check("e_sdata", o_sdata, 32'hDEADBEEF);
    end_cyc();
    tick(); check("e_err_once", o_serr, 0);

    // Abort during WAIT, then a late ack
    start(0, 12'h034, 32'h0, 4'hF);
    tick(); tick(); end_cyc();
    tick(); check("a_cyc", o_mcyc, 0); i_mack = 1; i_mdata = 32'h77;
    tick(); i_mack = 0; check("a_noack", o_sack, 0); check("a_noerr", o_serr, 0);
    check("a_sdata", o_sdata, 32'hDEADBEEF);

    // Back-to-back requests with the strobe held through the ack cycle
    start(0, 12'h040, 32'h0, 4'hF);
    tick(); tick(); i_mack = 1; i_mdata = 32'h11111111;
    tick(); i_mack = 0; check("b_ack1", o_sack, 1); i_saddr = 12'h044;
    tick(); check("b_gap", o_mstb, 0);
    tick(); check("b_stb", o_mstb, 1); check("b_addr", o_maddr, 12'h044);
    tick(); i_mack = 1; i_mdata = 32'h22222222;
    tick(); i_mack = 0; check("b_ack2", o_sack, 1); check("b_dat2", o_sdata, 32'h22222222); end_cyc();
    tick();

    // Abort while stalled in REQ
    start(1, 12'h050, 32'hA5A5A5A5, 4'h1); i_mstall = 1;
    tick(); end_cyc();
    tick(); check("ar_cyc", o_mcyc, 0); check("ar_stb", o_mstb, 0); i_mstall = 0;
    tick();

    // Ack during REQ is a protocol violation and is ignored
    start(0, 12'h060, 32'h0, 4'hF); i_mstall = 1;
    tick(); i_mack = 1; i_mdata = 32'h99;
    tick(); check("q_stb", o_mstb, 1); check("q_noack", o_sack, 0); i_mack = 0; i_mstall = 0;
    tick(); i_mack = 1; i_mdata = 32'h33333333;
    tick(); i_mack = 0; check("q_ack", o_sack, 1); check("q_dat", o_sdata, 32'h33333333); end_cyc();
    tick();

    // Reset mid-transaction drops the cycle at once and clears read data
    start(0, 12'h070, 32'h0, 4'hF);
    tick(); tick();
    #1 i_reset = 1; end_cyc();
    #1 check("x_cyc", o_mcyc, 0); check("x_sdata", o_sdata, 0);
    tick(); i_reset = 0; i_mack = 1;
    tick(); i_mack = 0; check("x_noack", o_sack, 0);
    start(0, 12'h0AB, 32'h0, 4'hF);
    tick(); check("x_stb", o_mstb, 1); check("x_addr", o_maddr, 12'h0AB);
    tick(); i_mack = 1; i_mdata = 32'hCAFEF00D;
    tick(); i_mack = 0; check("x_ack", o_sack, 1); check("x_dat", o_sdata, 32'hCAFEF00D); end_cyc();
    tick();

    // Silent slave: watchdog error at cycle 16 after REQ entry, or an indefinite wait without it
    start(0, 12'h0F0, 32'h0, 4'hF);
    tick();
`ifdef WBC2PIPELINE_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin check("t_early", o_serr, 0); check("t_cyc15", o_mcyc, 1); end
      if (k == 16) begin check("t_err", o_serr, 1); check("t_cyc", o_mcyc, 0); end
    end
    end_cyc(); i_mack = 1;
    tick(); i_mack = 0; check("t_late", o_sack, 0);
`else
    repeat (20) tick();
    check("t_hold_cyc", o_mcyc, 1); check("t_hold_err", o_serr, 0);
    end_cyc();
    tick(); check("t_abort", o_mcyc, 0);
`endif
    tick(); tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
